bitscan_encoder: RTL and testbench

//   Sequential, parametrised priority encoder. Accepts a WIDTH-bit request vector

---
 rtl/bitscan_encoder.sv | 105 ++++++++++
 tb/tb_bitscan_encoder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitscan_encoder.sv
// Sequential priority encoder: accepts a request vector and emits the index
// of each set bit, one per output beat, in priority order.
module bitscan_encoder #(
  parameter int WIDTH     = 8,
  parameter int IDXW      = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             zero_seen
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             last_q, last_d;
  logic             zero_q, zero_d;

  function automatic logic [IDXW-1:0] pick(
    input logic [WIDTH-1:0] v
  );
    logic [IDXW-1:0] r;
    r = '0;
    // Later hits overwrite earlier ones, so scan toward the winning end.
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (v[i]) r = IDXW'(i);
      end else begin
        if (v[WIDTH-1-i]) r = IDXW'(WIDTH-1-i);
      end
    end
    return r;
  endfunction

  function automatic logic one_left(
    input logic [WIDTH-1:0] v
  );
    return (v != '0) &&
      ((v & (v - WIDTH'(1))) == '0);
  endfunction

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != '0) begin
            pend_d  = in_vec;
            state_d = SCAN;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (out_ready) begin
          pend_d = pend_q &
            ~(WIDTH'(1) << idx_q);
          if (last_q) state_d = IDLE;
        end
      end
    endcase
    idx_d  = (state_d == SCAN) ?
      pick(pend_d) : '0;
    last_d = (state_d == SCAN) &&
      one_left(pend_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == SCAN);
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign zero_seen = zero_q;

endmodule

// File: tb/tb_bitscan_encoder.sv
// Bench for bitscan_encoder: LSB-first, MSB-first and 16-bit instances
// compared against a bit-list reference model.
module tb_bitscan_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = '0;
  logic       out_ready = 1'b0;

  logic       l_in_ready, l_out_valid, l_out_last, l_zero;
  logic [2:0] l_idx;
  logic       m_in_ready, m_out_valid, m_out_last, m_zero;
  logic [2:0] m_idx;

  logic        w_in_valid = 1'b0;
  logic [15:0] w_in_vec = '0;
  logic        w_out_ready = 1'b0;
  logic        w_in_ready, w_out_valid, w_out_last, w_zero;
  logic [3:0]  w_idx;

  bitscan_encoder #(.WIDTH(8), .IDXW(3), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(l_in_ready), .in_vec(in_vec),
    .out_valid(l_out_valid), .out_ready(out_ready),
    .out_idx(l_idx), .out_last(l_out_last), .zero_seen(l_zero)
  );

  bitscan_encoder #(.WIDTH(8), .IDXW(3), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(m_in_ready), .in_vec(in_vec),
    .out_valid(m_out_valid), .out_ready(out_ready),
    .out_idx(m_idx), .out_last(m_out_last), .zero_seen(m_zero)
  );

  bitscan_encoder #(.WIDTH(16), .IDXW(4), .MSB_FIRST(1'b0)) u_w16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_vec(w_in_vec),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_idx(w_idx), .out_last(w_out_last), .zero_seen(w_zero)
  );

  // Drive one vector into both 8-bit instances; stall_pct sets how often
  // out_ready is dropped. Expected order is the list of set bit positions.
  task automatic scan8(input logic [7:0] v, input int stall_pct);
    int lq[$];
    int mq[$];
    int n, k, cyc;
    bit rdy;
    for (int i = 0; i < 8; i++) if (v[i]) lq.push_back(i);
    for (int i = 7; i >= 0; i--) if (v[i]) mq.push_back(i);
    n = lq.size();
    @(negedge clk);
    checks++;
    if (l_in_ready !== 1'b1 || m_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before v=%h: got %b/%b want 1", v, l_in_ready, m_in_ready);
    end
    in_valid = 1'b1;
    in_vec = v;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_vec = $urandom;
    cyc = 1;
    if (n == 0) begin
      checks++;
      if (l_zero !== 1'b1 || m_zero !== 1'b1 || l_out_valid !== 1'b0 ||
          l_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL zero_pulse: got z=%b/%b ov=%b rdy=%b want z=1 ov=0 rdy=1",
                 l_zero, m_zero, l_out_valid, l_in_ready);
      end
      @(negedge clk);
      checks++;
      if (l_zero !== 1'b0 || m_zero !== 1'b0 || l_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_once: got z=%b/%b ov=%b want 0", l_zero, m_zero, l_out_valid);
      end
      return;
    end
    k = 0;
    while (k < n && cyc < 300) begin
      checks++;
      if (l_out_valid !== 1'b1 || l_idx !== 3'(lq[k]) ||
          l_out_last !== (k == n - 1) || l_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL lsb_beat v=%h k=%0d: got ov=%b idx=%0d last=%b rdy=%b want ov=1 idx=%0d last=%b rdy=0",
                 v, k, l_out_valid, l_idx, l_out_last, l_in_ready, lq[k], k == n - 1);
      end
      checks++;
      if (m_out_valid !== 1'b1 || m_idx !== 3'(mq[k]) ||
          m_out_last !== (k == n - 1)) begin
        errors++;
        $display("FAIL msb_beat v=%h k=%0d: got ov=%b idx=%0d last=%b want ov=1 idx=%0d last=%b",
                 v, k, m_out_valid, m_idx, m_out_last, mq[k], k == n - 1);
      end
      rdy = ($urandom_range(99) >= stall_pct);
      out_ready = rdy;
      in_valid = $urandom_range(1);
      @(negedge clk);
      cyc++;
      if (rdy) k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL scan_timeout v=%h: got %0d beats want %0d", v, k, n);
    end
    checks++;
    if (l_out_valid !== 1'b0 || l_in_ready !== 1'b1 || l_idx !== 3'd0 ||
        l_out_last !== 1'b0 || m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after v=%h: got ov=%b rdy=%b idx=%0d last=%b want 0,1,0,0",
               v, l_out_valid, l_in_ready, l_idx, l_out_last);
    end
    if (stall_pct == 0) begin
      checks++;
      if (cyc != n + 1) begin
        errors++;
        $display("FAIL busy_time v=%h: got %0d want %0d", v, cyc, n + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_vec = 8'h55;
    w_in_valid = 1'b1;
    w_in_vec = 16'h0F0F;
    repeat (3) @(negedge clk);
    checks++;
    if (l_out_valid !== 1'b0 || l_in_ready !== 1'b0 || l_zero !== 1'b0 ||
        m_out_valid !== 1'b0 || w_out_valid !== 1'b0 || w_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got ov=%b rdy=%b z=%b want 0,0,0",
               l_out_valid, l_in_ready, l_zero);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    w_in_valid = 1'b0;
    #1;
    checks++;
    if (l_in_ready !== 1'b1 || m_in_ready !== 1'b1 || w_in_ready !== 1'b1 ||
        l_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b/%b/%b want 1", l_in_ready, m_in_ready, w_in_ready);
    end
  endtask

  task automatic test_lsb_order();
    scan8(8'b1010_0101, 0);
  endtask

  task automatic test_msb_first();
    scan8(8'h81, 0);
  endtask

  task automatic test_stall();
    @(negedge clk);
    in_valid = 1'b1;
    in_vec = 8'h0C;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (l_out_valid !== 1'b1 || l_idx !== 3'd2 || l_out_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold c=%0d: got ov=%b idx=%0d last=%b want 1,2,0",
                 i, l_out_valid, l_idx, l_out_last);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (l_idx !== 3'd2) begin
      errors++;
      $display("FAIL stall_first: got %0d want 2", l_idx);
    end
    @(negedge clk);
    checks++;
    if (l_out_valid !== 1'b1 || l_idx !== 3'd3 || l_out_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_second: got ov=%b idx=%0d last=%b want 1,3,1",
               l_out_valid, l_idx, l_out_last);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (l_out_valid !== 1'b0 || l_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got ov=%b rdy=%b want 0,1", l_out_valid, l_in_ready);
    end
    scan8(8'h5A, 60);
  endtask

  task automatic test_edge_vectors();
    scan8(8'h00, 0);
    scan8(8'hFF, 0);
    scan8(8'h80, 0);
    scan8(8'h01, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      scan8((t % 7 == 3) ? 8'h00 : 8'($urandom), (t < 10) ? 0 : 35);
    end
  endtask

  task automatic test_reset_midscan();
    @(negedge clk);
    in_valid = 1'b1;
    in_vec = 8'hF0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (l_out_valid !== 1'b1 || l_idx !== 3'd4) begin
      errors++;
      $display("FAIL mid_first: got ov=%b idx=%0d want 1,4", l_out_valid, l_idx);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (l_out_valid !== 1'b0 || m_out_valid !== 1'b0 || l_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got ov=%b/%b rdy=%b want 0,0,0",
               l_out_valid, m_out_valid, l_in_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (l_out_valid !== 1'b0 || l_in_ready !== 1'b1 || l_idx !== 3'd0) begin
        errors++;
        $display("FAIL mid_after c=%0d: got ov=%b rdy=%b idx=%0d want 0,1,0",
                 i, l_out_valid, l_in_ready, l_idx);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wide16();
    logic [15:0] v;
    int q[$];
    int k, cyc;
    for (int t = 0; t < 6; t++) begin
      v = (t == 0) ? 16'h8001 : 16'($urandom) | 16'h0001;
      q.delete();
      for (int i = 0; i < 16; i++) if (v[i]) q.push_back(i);
      @(negedge clk);
      w_in_valid = 1'b1;
      w_in_vec = v;
      w_out_ready = 1'b1;
      @(negedge clk);
      w_in_valid = 1'b0;
      k = 0;
      cyc = 0;
      while (k < q.size() && cyc < 40) begin
        checks++;
        if (w_out_valid !== 1'b1 || w_idx !== 4'(q[k]) ||
            w_out_last !== (k == q.size() - 1)) begin
          errors++;
          $display("FAIL w16_beat v=%h k=%0d: got ov=%b idx=%0d last=%b want 1,%0d,%b",
                   v, k, w_out_valid, w_idx, w_out_last, q[k], k == q.size() - 1);
        end
        @(negedge clk);
        k++;
        cyc++;
      end
      checks++;
      if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL w16_idle v=%h: got ov=%b rdy=%b want 0,1", v, w_out_valid, w_in_ready);
      end
      w_out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_lsb_order();
    test_msb_first();
    test_stall();
    test_edge_vectors();
    test_random();
    test_reset_midscan();
    test_wide16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
